// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multiport register file.
//   clr_state_e      : states of the whole-file clear sequencer
//   RF_XLEN_DEFAULT  : default register width in bits
//   RF_DEPTH_DEFAULT : default number of registers
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_XLEN_DEFAULT  = 64;
    localparam int RF_DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// Sequencer that walks every register index once to zero the file.
// A clear occupies DEPTH cycles in CLEAR (one index per cycle) followed by a
// single DONE cycle that raises clr_done.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_req    : start a clear (ignored unless idle)
//   clr_busy   : high in CLEAR and DONE
//   clr_done   : one-cycle pulse in DONE
//   clr_we     : high while the current index is being zeroed
//   clr_idx    : register index being zeroed this cycle
// ---------------------------------------------------------------------------
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and index registers; reset aborts any clear in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: the index advances every CLEAR cycle and the last
    // index hands over to DONE, which always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = (state_q == ST_DONE);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_idx  = idx_q;

endmodule

// File: rtl/multiport_register_file.sv
// ---------------------------------------------------------------------------
// multiport_register_file
// Register file with NRD combinational read ports, two write ports and a
// sequenced whole-file clear.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (zeroes every register)
//   rd_addr   : NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data   : NRD packed read data, port k at [k*XLEN +: XLEN]
//   wr_en     : per-write-port enable (2 ports, port 1 wins on collisions)
//   wr_addr   : packed write addresses
//   wr_data   : packed write data
//   clr_req   : request to zero the whole file
//   clr_busy  : clear in progress; user writes are dropped meanwhile
//   clr_done  : one-cycle pulse when a clear finishes
// Build option: define RF_BYPASS_EN to forward same-cycle write data to
// matching reads; otherwise reads show the pre-edge contents.
// ---------------------------------------------------------------------------
module multiport_register_file
    import rf_pkg::*;
#(
    parameter  int XLEN     = RF_XLEN_DEFAULT,
    parameter  int DEPTH    = RF_DEPTH_DEFAULT,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [1:0]          wr_en,
    input  logic [2*AW-1:0]     wr_addr,
    input  logic [2*XLEN-1:0]   wr_data,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [XLEN-1:0] regs_d [DEPTH];

    logic            clr_we;
    logic [AW-1:0]   clr_idx;

    logic [AW-1:0]   wa     [2];
    logic [XLEN-1:0] wd     [2];
    logic [1:0]      wr_ok;

    rf_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // A write is accepted only outside a clear, and never into a hardwired
    // zero register; the same qualifier gates the bypass path.
    for (genvar w = 0; w < 2; w++) begin : g_wr
        assign wa[w]    = wr_addr[w*AW +: AW];
        assign wd[w]    = wr_data[w*XLEN +: XLEN];
        assign wr_ok[w] = wr_en[w] && !clr_busy &&
                          !((ZERO_REG != 0) && (wa[w] == '0));
    end

    // Next contents of the file: port 0 is applied before port 1 so that
    // port 1 overwrites it on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_idx] = '0;
        end
        if (wr_ok[0]) begin
            regs_d[wa[0]] = wd[0];
        end
        if (wr_ok[1]) begin
            regs_d[wa[1]] = wd[1];
        end
    end

    // Storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: address 0 reads as zero when it is the hardwired register.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] stored;

        assign ra     = rd_addr[k*AW +: AW];
        assign stored = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs_q[ra];

`ifdef RF_BYPASS_EN
        assign rd_data[k*XLEN +: XLEN] =
            (wr_ok[1] && (wa[1] == ra)) ? wd[1] :
            (wr_ok[0] && (wa[0] == ra)) ? wd[0] : stored;
`else
        assign rd_data[k*XLEN +: XLEN] = stored;
`endif
    end

endmodule
